// File: rtl/program_counter_unit.sv
// ============================================================================
// program_counter_unit : fetch PC sequencer with trap/flush redirect and RAS
// Rev 1.0
// ============================================================================
`default_nettype none

module program_counter_unit #(
    parameter int                 DWIDTH       = 32,
    parameter logic [DWIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic              Trap,
    input  logic [DWIDTH-1:0] Trap_Vector,
    input  logic              Flush,
    input  logic [DWIDTH-1:0] Flush_Target,
    input  logic              Stall,
    input  logic              PC_Sel,
    input  logic [DWIDTH-1:0] Program_Count_Imm,
    input  logic              Ras_Push,
    input  logic              Ras_Pop,
    input  logic              Imem_Ready,
    output logic              Imem_Req,
    output logic [DWIDTH-1:0] Program_Count,
    output logic [DWIDTH-1:0] Program_Count_Off,
    output logic              Ras_Empty
);

    localparam int                C_PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                C_CNT_W   = C_PTR_W + 1;
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(RAS_DEPTH);
    localparam logic [DWIDTH-1:0]  C_INSN_SZ = DWIDTH'(4);

    logic [DWIDTH-1:0]  r_pc;
    logic               r_run;
    logic [C_PTR_W-1:0] r_top;
    logic [C_CNT_W-1:0] r_count;
    logic [DWIDTH-1:0]  r_ras [RAS_DEPTH];

    logic               w_advance;
    logic               w_ctl_ok;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;
    logic [DWIDTH-1:0]  w_pc_off;
    logic [DWIDTH-1:0]  w_pc_next;

    assign w_pc_off  = r_pc + C_INSN_SZ;
    assign w_empty   = (r_count == '0);
    assign Imem_Req  = r_run & ~Stall;
    assign w_advance = Imem_Req & Imem_Ready;
    // Stack side effects only happen on a real fetch that is not being redirected.
    assign w_ctl_ok  = w_advance & ~Trap & ~Flush;
    assign w_do_push = w_ctl_ok & Ras_Push;
    assign w_do_pop  = w_ctl_ok & Ras_Pop & ~w_empty;

    always_comb begin
        w_pc_next = w_pc_off;
        if (Trap)
            w_pc_next = Trap_Vector;
        else if (Flush)
            w_pc_next = Flush_Target;
        else if (!w_advance)
            w_pc_next = r_pc;
        else if (Ras_Pop && !w_empty)
            w_pc_next = r_ras[r_top];
        else if (PC_Sel)
            w_pc_next = Program_Count_Imm;
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            r_pc  <= RESET_VECTOR;
            r_run <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (Trap) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_top <= r_top + C_PTR_ONE;
            if (r_count != C_CNT_MAX)
                r_count <= r_count + C_CNT_ONE;
        end else if (w_do_pop && !w_do_push) begin
            r_top   <= r_top - C_PTR_ONE;
            r_count <= r_count - C_CNT_ONE;
        end
    end

    // Entry storage carries no reset; a full stack simply wraps over the oldest slot.
    always_ff @(posedge Clk_Core) begin
        if (w_do_push) begin
            if (w_do_pop)
                r_ras[r_top] <= w_pc_off;
            else
                r_ras[r_top + C_PTR_ONE] <= w_pc_off;
        end
    end

    assign Program_Count     = r_pc;
    assign Program_Count_Off = w_pc_off;
    assign Ras_Empty         = w_empty;

endmodule

`default_nettype wire
